// File: rtl/instr_encoder_loader.sv
// Packs decoded RV32I descriptors (R/I/B/J/U) into instruction words and streams them
// sequentially into instruction memory through a held-until-accepted write port.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   count
);

    localparam logic [2:0] TypeR = 3'd0;
    localparam logic [2:0] TypeI = 3'd1;
    localparam logic [2:0] TypeB = 3'd2;
    localparam logic [2:0] TypeJ = 3'd3;
    localparam logic [2:0] TypeU = 3'd4;

    localparam logic [6:0] OpR = 7'b0110011;
    localparam logic [6:0] OpI = 7'b0010011;
    localparam logic [6:0] OpB = 7'b1100011;
    localparam logic [6:0] OpJ = 7'b1101111;
    localparam logic [6:0] OpU = 7'b0110111;

    localparam logic [ADDR_W:0] DepthC = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                last_seen_q, last_seen_d;
    logic                pend_last_q, pend_last_d;

    // Encoder
    logic        shift_op;
    logic        r_alt;
    logic        i_alt;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;
    logic        shamt_ok;
    logic        b_f3_ok;
    logic [31:0] enc_word;
    logic        enc_ok;

    // Sign-extension checks: every bit above the field's sign bit must equal it.
    assign fits_12  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits_13  = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits_21  = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    assign shamt_ok = ~(|in_imm[31:5]);
    assign shift_op = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign r_alt    = in_alt & ((in_funct3 == 3'b000) || (in_funct3 == 3'b101));
    assign i_alt    = in_alt & in_funct3[2];
    assign b_f3_ok  = (in_funct3 != 3'b010) && (in_funct3 != 3'b011);

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (in_type)
            TypeR: begin
                enc_word = {1'b0, r_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OpR};
                enc_ok   = 1'b1;
            end
            TypeI: begin
                if (shift_op) begin
                    enc_word = {1'b0, i_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OpI};
                    enc_ok   = shamt_ok;
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpI};
                    enc_ok   = fits_12;
                end
            end
            TypeB: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OpB};
                enc_ok   = ~in_imm[0] & fits_13 & b_f3_ok;
            end
            TypeJ: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OpJ};
                enc_ok   = ~in_imm[0] & fits_21;
            end
            TypeU: begin
                enc_word = {in_imm[31:12], in_rd, OpU};
                enc_ok   = ~(|in_imm[11:0]);
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // Handshake and write-port bookkeeping
    logic              drain;
    logic              full;
    logic              accept;
    logic [ADDR_W-1:0] addr_after;

    assign drain      = mem_we_q & mem_ready;
    assign addr_after = drain ? (mem_addr_q + ADDR_W'(1)) : mem_addr_q;
    // Count the outstanding write too, so a slot is never promised beyond DEPTH.
    assign full       = (count_q + {{ADDR_W{1'b0}}, mem_we_q}) >= DepthC;
    assign in_ready   = (state_q == StLoad) & ~full & ~last_seen_q & (~mem_we_q | mem_ready);
    assign accept     = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        count_d     = count_q;
        last_seen_d = last_seen_q;
        pend_last_d = pend_last_q;

        if (start) begin
            state_d     = StLoad;
            mem_we_d    = 1'b0;
            mem_addr_d  = base_addr;
            err_d       = 1'b0;
            err_addr_d  = '0;
            count_d     = '0;
            last_seen_d = 1'b0;
            pend_last_d = 1'b0;
        end else if (state_q == StLoad) begin
            if (drain) begin
                mem_we_d   = 1'b0;
                mem_addr_d = addr_after;
                count_d    = count_q + (ADDR_W+1)'(1);
                if (pend_last_q || ((count_q + (ADDR_W+1)'(1)) == DepthC)) begin
                    state_d = StDone;
                end
            end
            if (accept) begin
                last_seen_d = in_last;
                if (enc_ok) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_after;
                    mem_wdata_d = enc_word;
                    pend_last_d = in_last;
                end else begin
                    err_d = 1'b1;
                    if (!err_q) begin
                        err_addr_d = addr_after;
                    end
                    if (in_last) begin
                        state_d = StDone;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            count_q     <= count_d;
            last_seen_q <= last_seen_d;
            pend_last_q <= pend_last_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign err_addr  = err_addr_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized checks of instr_encoder_loader against an arithmetic reference model
// of the RV32I encoding, the load handshake and the error bookkeeping.
module tb_instr_encoder_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned DP = 12;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, in_alt, in_last;
    logic [AW-1:0] base_addr;
    logic [2:0]    in_type, in_funct3;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          mem_we, mem_ready, done, err;
    logic [AW-1:0] mem_addr, err_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_funct3(in_funct3),
        .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .done(done), .err(err), .err_addr(err_addr), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int failed = 0;
    bit rand_ready = 1'b0;

    logic [AW+31:0] obs_q[$];
    logic [AW+31:0] exp_q[$];

    // Imem side: record every completed write.
    always begin
        @(negedge clk);
        #2;
        if (!rst && !start && mem_we && mem_ready) obs_q.push_back({mem_addr, mem_wdata});
    end

    // Reference model state
    int m_addr, m_count, m_err_addr;
    bit m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit model_ok(int t, int f3, logic [31:0] imm);
        int v = int'(imm);
        case (t)
            0: return 1'b1;
            1: if (f3 == 1 || f3 == 5) return v >= 0 && v <= 31;
               else return v >= -2048 && v <= 2047;
            2: return f3 != 2 && f3 != 3 && v % 2 == 0 && v >= -4096 && v <= 4094;
            3: return v % 2 == 0 && v >= -(1 << 20) && v <= (1 << 20) - 2;
            4: return imm % 4096 == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_word(int t, int f3, bit alt, int rd, int rs1, int rs2,
                                               logic [31:0] imm);
        int v = int'(imm);
        longint w = 0;
        longint regs = longint'(rd) * 128 + longint'(f3) * 4096 + longint'(rs1) * 32768;
        case (t)
            0: w = 51 + regs + longint'(rs2) * (64'd1 << 20)
                   + ((alt && (f3 == 0 || f3 == 5)) ? (64'd1 << 30) : 0);
            1: if (f3 == 1 || f3 == 5)
                   w = 19 + regs + longint'(v % 32) * (64'd1 << 20)
                       + ((alt && f3 == 5) ? (64'd1 << 30) : 0);
               else
                   w = 19 + regs + longint'((v + 4096) % 4096) * (64'd1 << 20);
            2: w = 99 + longint'((v >>> 11) & 1) * 128 + longint'((v >>> 1) & 15) * 256
                   + longint'(f3) * 4096 + longint'(rs1) * 32768 + longint'(rs2) * (64'd1 << 20)
                   + longint'((v >>> 5) & 63) * (64'd1 << 25)
                   + longint'((v >>> 12) & 1) * (64'd1 << 31);
            3: w = 111 + longint'(rd) * 128 + longint'((v >>> 12) & 255) * 4096
                   + longint'((v >>> 11) & 1) * (64'd1 << 20)
                   + longint'((v >>> 1) & 1023) * (64'd1 << 21)
                   + longint'((v >>> 20) & 1) * (64'd1 << 31);
            4: w = 55 + longint'(rd) * 128 + longint'(imm / 4096) * 4096;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic model_start(input int base);
        m_addr = base;
        m_count = 0;
        m_err = 1'b0;
        m_err_addr = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input int t, input int f3, input bit alt, input int rd,
                                input int rs1, input int rs2, input logic [31:0] imm);
        if (model_ok(t, f3, imm)) begin
            exp_q.push_back({AW'(m_addr), model_word(t, f3, alt, rd, rs1, rs2, imm)});
            m_addr = (m_addr + 1) % (1 << AW);
            m_count++;
        end else if (!m_err) begin
            m_err = 1'b1;
            m_err_addr = m_addr;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input int t, input int f3, input bit alt, input int rd, input int rs1,
                         input int rs2, input logic [31:0] imm, input bit last);
        in_type = t[2:0];
        in_funct3 = f3[2:0];
        in_alt = alt;
        in_rd = rd[4:0];
        in_rs1 = rs1[4:0];
        in_rs2 = rs2[4:0];
        in_imm = imm;
        in_last = last;
        in_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int t, input int f3, input bit alt, input int rd, input int rs1,
                        input int rs2, input logic [31:0] imm, input bit last);
        int n = 0;
        drive(t, f3, alt, rd, rs1, rs2, imm, last);
        #1;
        while (!in_ready && n < 200) begin
            tick();
            #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        model_accept(t, f3, alt, rd, rs1, rs2, imm);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic do_start(input int base);
        base_addr = base[AW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start(base);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_err_addr"}, 64'(err_addr), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_type = '0;
        in_funct3 = '0; in_alt = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        in_last = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // Single-word latency and back-to-back streaming
        mem_ready = 1'b1;
        do_start(3);
        send(1, 0, 0, 1, 0, 0, 32'd5, 0);
        chk("addi_we", 64'(mem_we), 64'd1);
        chk("addi_addr", 64'(mem_addr), 64'd3);
        chk("addi_word", 64'(mem_wdata), 64'h00500093);
        send(0, 0, 0, 3, 1, 2, 32'd0, 0);
        chk("add_addr", 64'(mem_addr), 64'd4);
        chk("add_word", 64'(mem_wdata), 64'h002081B3);
        send(0, 0, 1, 3, 1, 2, 32'd0, 0);
        chk("sub_addr", 64'(mem_addr), 64'd5);
        chk("sub_word", 64'(mem_wdata), 64'h402081B3);
        chk("sub_count", 64'(count), 64'd2);
        send(2, 0, 0, 0, 1, 2, 32'd8, 0);
        chk("beq_word", 64'(mem_wdata), 64'h00208463);
        send(3, 0, 0, 1, 0, 0, 32'd16, 0);
        chk("jal_word", 64'(mem_wdata), 64'h010000EF);
        send(4, 0, 0, 5, 0, 0, 32'h12345000, 0);
        chk("lui_word", 64'(mem_wdata), 64'h123452B7);
        send(1, 5, 1, 4, 1, 0, 32'd3, 0);
        chk("srai_addr", 64'(mem_addr), 64'd9);
        chk("srai_word", 64'(mem_wdata), 64'h4030D213);

        // Backpressure: pending write must hold steady
        mem_ready = 1'b0;
        drive(0, 0, 0, 3, 1, 2, 32'd0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("stall_we", 64'(mem_we), 64'd1);
            chk("stall_addr", 64'(mem_addr), 64'd9);
            chk("stall_word", 64'(mem_wdata), 64'h4030D213);
            chk("stall_ready", 64'(in_ready), 64'd0);
        end
        mem_ready = 1'b1;
        send(0, 0, 0, 3, 1, 2, 32'd0, 0);
        chk("resume_addr", 64'(mem_addr), 64'd10);
        chk("resume_word", 64'(mem_wdata), 64'h002081B3);
        chk("resume_count", 64'(count), 64'd7);
        // Rejected last descriptor (B with funct3=010) still ends the load
        send(2, 2, 0, 0, 1, 2, 32'd8, 1);
        chk("rejlast_done", 64'(done), 64'd1);
        chk("rejlast_err", 64'(err), 64'd1);
        chk("rejlast_err_addr", 64'(err_addr), 64'd11);
        chk("rejlast_we", 64'(mem_we), 64'd0);
        chk("rejlast_count", 64'(count), 64'd8);

        // Out-of-range I immediate, then a good word fills the same slot
        do_start(7);
        chk("restart_err", 64'(err), 64'd0);
        send(1, 0, 0, 1, 0, 0, 32'd4096, 0);
        chk("badimm_err", 64'(err), 64'd1);
        chk("badimm_err_addr", 64'(err_addr), 64'd7);
        chk("badimm_we", 64'(mem_we), 64'd0);
        send(1, 0, 0, 1, 0, 0, 32'd5, 0);
        chk("after_err_we", 64'(mem_we), 64'd1);
        chk("after_err_addr", 64'(mem_addr), 64'd7);
        chk("after_err_word", 64'(mem_wdata), 64'h00500093);

        // Fill to DEPTH, crossing the address wrap
        do_start(14);
        for (int i = 0; i < int'(DP); i++) send(1, 0, 0, 1, 0, 0, 32'(i), 0);
        drive(1, 0, 0, 1, 0, 0, 32'd99, 0);
        tick();
        #1;
        chk("full_done", 64'(done), 64'd1);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'(DP));
        chk("full_addr", 64'(mem_addr), 64'((14 + DP) % (1 << AW)));
        chk("wrap_last_write", 64'(obs_q[obs_q.size() - 1]), {28'd0, 4'd9, 32'h00B00093});
        in_valid = 1'b0;

        // Reset while a write is stalled
        do_start(2);
        mem_ready = 1'b0;
        send(1, 0, 0, 1, 0, 0, 32'd5, 0);
        tick();
        chk("prerst_we", 64'(mem_we), 64'd1);
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;

        // Randomized rounds against the reference model
        for (int r = 0; r < 8; r++) begin
            int n, mark, nd;
            rand_ready = 1'b1;
            do_start(int'($urandom_range(0, (1 << AW) - 1)));
            mark = obs_q.size();
            nd = int'($urandom_range(3, 10));
            for (int k = 0; k < nd; k++) begin
                int t, f3;
                logic [31:0] imm;
                t = int'($urandom_range(0, 6));
                f3 = int'($urandom_range(0, 7));
                case (t)
                    1: imm = (f3 == 1 || f3 == 5) ? 32'($urandom_range(0, 31))
                                                 : 32'(int'($urandom_range(0, 4095)) - 2048);
                    2: imm = 32'(2 * int'($urandom_range(0, 4095)) - 4096);
                    3: imm = 32'(2 * int'($urandom_range(0, (1 << 20) - 1)) - (1 << 20));
                    4: imm = $urandom & 32'hFFFFF000;
                    default: imm = $urandom;
                endcase
                if ($urandom_range(0, 4) == 0) imm = imm + (32'd1 << $urandom_range(0, 21));
                send(t, f3, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm,
                     k == nd - 1);
            end
            n = 0;
            while (!done && n < 300) begin
                tick();
                #1;
                n++;
            end
            chk("rnd_done", 64'(done), 64'd1);
            chk("rnd_count", 64'(count), 64'(m_count));
            chk("rnd_err", 64'(err), 64'(m_err));
            chk("rnd_err_addr", 64'(err_addr), 64'(m_err_addr));
            chk("rnd_nwrites", 64'(obs_q.size() - mark), 64'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && mark + i < obs_q.size(); i++)
                chk("rnd_write", 64'(obs_q[mark + i]), 64'(exp_q[i]));
        end
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
